// File: rtl/counter_pkg.sv
// Shared types and helpers for the step counter: mode/state encodings and
// the per-mode step and low-bound rules.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_ODD  = 2'b00,
        MODE_EVEN = 2'b01,
        MODE_UNIT = 2'b10,
        MODE_PROG = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Callers cast the result down to their own WIDTH+1, so WIDTH must stay below 32.
    function automatic logic [31:0] eff_step(input mode_t m, input logic [31:0] s);
        logic [31:0] r;
        r = 32'd1;
        case (m)
            MODE_ODD:  r = 32'd2;
            MODE_EVEN: r = 32'd2;
            MODE_UNIT: r = 32'd1;
            MODE_PROG: r = (s == 32'd0) ? 32'd1 : s;
            default:   r = 32'd1;
        endcase
        return r;
    endfunction

    function automatic logic low_bound(input mode_t m);
        return (m == MODE_ODD);
    endfunction

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-value generator: advances the count by the effective step
// and flags the terminal condition using one extra bit so nothing wraps silently.
module step_counter_next #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH:0]   i_step,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_next,
    output logic             o_term
);

    logic [WIDTH:0]   w_up;
    logic [WIDTH:0]   w_floor;
    logic [WIDTH-1:0] w_dn;
    logic             w_term_up;
    logic             w_term_dn;

    assign w_up      = {1'b0, i_cur} + i_step;
    assign w_floor   = i_step + {1'b0, i_lo};
    assign w_dn      = i_cur - i_step[WIDTH-1:0];
    assign w_term_up = (w_up > {1'b0, i_hi});
    assign w_term_dn = ({1'b0, i_cur} < w_floor);

    // An empty range (high bound below low bound) is terminal on every step.
    assign o_term = (i_hi < i_lo) || (i_dir ? w_term_dn : w_term_up);

    always_comb begin
        o_next = i_dir ? w_dn : w_up[WIDTH-1:0];
        if (o_term) begin
            o_next = i_dir ? i_hi : i_lo;
        end
    end

endmodule

// File: rtl/step_counter.sv
// Configurable up/down step counter with odd/even/unit/programmable sequences,
// wrap-or-saturate terminal behaviour and a one-cycle terminal pulse.
module step_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int SW = WIDTH + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    mode_t            r_mode;
    logic             r_dir;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] r_out;
    logic             r_tc;

    mode_t            w_ld_mode;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_ld_lo;
    logic [WIDTH-1:0] w_ld_hi;
    logic [WIDTH-1:0] w_ld_base;
    logic [WIDTH:0]   w_step_eff;
    logic [WIDTH-1:0] w_next;
    logic             w_term;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_tc_nxt;

    function automatic logic [WIDTH-1:0] hi_bound(input mode_t m, input logic [WIDTH-1:0] lim);
        logic [WIDTH-1:0] h;
        h = lim;
        if (m == MODE_ODD) begin
            h = {lim[WIDTH-1:1], 1'b1};
        end else if (m == MODE_EVEN) begin
            h = {lim[WIDTH-1:1], 1'b0};
        end
        return h;
    endfunction

    assign w_ld_mode = mode_t'(mode);

    // Bounds exist twice: from the latched configuration while running, and
    // from the live inputs so a start can load its base on the same edge.
    always_comb begin
        w_lo       = '0;
        w_lo[0]    = low_bound(r_mode);
        w_ld_lo    = '0;
        w_ld_lo[0] = low_bound(w_ld_mode);
        w_hi       = hi_bound(r_mode, r_limit);
        w_ld_hi    = hi_bound(w_ld_mode, limit);
        w_ld_base  = dir ? w_ld_hi : w_ld_lo;
    end

    assign w_step_eff = SW'(eff_step(r_mode, 32'(r_step)));

    step_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_cur  (r_out),
        .i_step (w_step_eff),
        .i_lo   (w_lo),
        .i_hi   (w_hi),
        .i_dir  (r_dir),
        .o_next (w_next),
        .o_term (w_term)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_tc_nxt    = 1'b0;
        if (start) begin
            w_state_nxt = ST_RUN;
            w_out_nxt   = w_ld_base;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_RUN: begin
                    if (en) begin
                        if (w_term) begin
                            w_tc_nxt = 1'b1;
                            if (SATURATE != 0) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_out_nxt = w_next;
                            end
                        end else begin
                            w_out_nxt = w_next;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_tc    <= 1'b0;
            r_mode  <= MODE_ODD;
            r_dir   <= 1'b0;
            r_step  <= '0;
            r_limit <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_tc    <= w_tc_nxt;
            if (start) begin
                r_mode  <= w_ld_mode;
                r_dir   <= dir;
                r_step  <= step;
                r_limit <= limit;
            end
        end
    end

    assign out       = r_out;
    assign tc        = r_tc;
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_step_counter.sv
// Directed scoreboard bench for step_counter: a wrapping and a saturating
// instance share stimulus; each expectation names which instance it targets.
module tb_step_counter;

    localparam int EW = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] step = 8'd0;
    logic [7:0] limit = 8'd0;

    logic [7:0] w_out;
    logic       w_busy;
    logic       w_tc;
    logic       w_done;
    logic [1:0] w_dbg;
    logic [7:0] s_out;
    logic       s_busy;
    logic       s_tc;
    logic       s_done;
    logic [1:0] s_dbg;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_fail = 0;

    step_counter #(.WIDTH(8), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .en(en), .dir(dir), .mode(mode),
        .step(step), .limit(limit), .out(w_out), .busy(w_busy), .tc(w_tc),
        .done(w_done), .dbg_state(w_dbg)
    );

    step_counter #(.WIDTH(8), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .en(en), .dir(dir), .mode(mode),
        .step(step), .limit(limit), .out(s_out), .busy(s_busy), .tc(s_tc),
        .done(s_done), .dbg_state(s_dbg)
    );

    always #5 clk = ~clk;

    // Expectation word: {instance select (1 = saturating), out, busy, tc, done}.
    function automatic logic [EW-1:0] ex(input logic sel, input logic [7:0] o,
                                         input logic b, input logic t, input logic d);
        return {sel, o, b, t, d};
    endfunction

    // Pushes the response expected after the next edge, then advances one cycle.
    task automatic tick(input logic [EW-1:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    always begin : monitor
        logic [EW-1:0] e;
        logic [EW-1:0] act;
        logic [1:0]    exp_st;
        logic [1:0]    act_st;
        string         nm;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            nm     = name_q.pop_front();
            act    = e[11] ? {1'b1, s_out, s_busy, s_tc, s_done}
                           : {1'b0, w_out, w_busy, w_tc, w_done};
            act_st = e[11] ? s_dbg : w_dbg;
            exp_st = e[2] ? 2'd1 : (e[0] ? 2'd2 : 2'd0);
            n_checks++;
            if (act !== e || act_st !== exp_st) begin
                n_fail++;
                $display("FAIL %s: got out=%0d busy=%0b tc=%0b done=%0b state=%0d, expected out=%0d busy=%0b tc=%0b done=%0b state=%0d",
                         nm, act[10:3], act[2], act[1], act[0], act_st,
                         e[10:3], e[2], e[1], e[0], exp_st);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        // Reset holds everything at zero, even with start and en asserted.
        tick(ex(0, 8'd0, 0, 0, 0), "reset_wrap");
        start = 1'b1; en = 1'b1;
        tick(ex(1, 8'd0, 0, 0, 0), "reset_sat_overrides_start");

        // Odd up, limit 9: 1,3,5,7,9 then reload to 1 with tc.
        rst = 1'b0; start = 1'b1; mode = 2'b00; dir = 1'b0; limit = 8'd9; en = 1'b1;
        tick(ex(0, 8'd1, 1, 0, 0), "odd_base");
        start = 1'b0;
        tick(ex(0, 8'd3, 1, 0, 0), "odd_3");
        tick(ex(0, 8'd5, 1, 0, 0), "odd_5");
        tick(ex(0, 8'd7, 1, 0, 0), "odd_7");
        tick(ex(0, 8'd9, 1, 0, 0), "odd_9");
        tick(ex(0, 8'd1, 1, 1, 0), "odd_wrap_tc");
        tick(ex(0, 8'd3, 1, 0, 0), "odd_after_wrap");

        // Programmable step 50 up to 255: no 8-bit overflow to 44.
        start = 1'b1; mode = 2'b11; step = 8'd50; limit = 8'd255;
        tick(ex(0, 8'd0, 1, 0, 0), "prog_base");
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick(ex(0, 8'(50 * i), 1, 0, 0), "prog_step");
        end
        tick(ex(0, 8'd0, 1, 1, 0), "prog_wrap_tc");

        // Unit mode with en pattern 1,0,0,1.
        start = 1'b1; mode = 2'b10; limit = 8'd255;
        tick(ex(0, 8'd0, 1, 0, 0), "unit_base");
        start = 1'b0;
        en = 1'b1; tick(ex(0, 8'd1, 1, 0, 0), "unit_en1");
        en = 1'b0; tick(ex(0, 8'd1, 1, 0, 0), "unit_hold_a");
        tick(ex(0, 8'd1, 1, 0, 0), "unit_hold_b");
        en = 1'b1; tick(ex(0, 8'd2, 1, 0, 0), "unit_en2");
        tick(ex(0, 8'd3, 1, 0, 0), "unit_3");
        tick(ex(0, 8'd4, 1, 0, 0), "unit_4");
        tick(ex(0, 8'd5, 1, 0, 0), "unit_5");

        // Reset mid-count, then IDLE ignores en.
        rst = 1'b1;
        tick(ex(0, 8'd0, 0, 0, 0), "rst_mid_count");
        rst = 1'b0;
        tick(ex(0, 8'd0, 0, 0, 0), "idle_ignores_en");

        // Restart mid-count into even-down; later input changes are not latched.
        start = 1'b1; mode = 2'b10; dir = 1'b0; limit = 8'd255;
        tick(ex(0, 8'd0, 1, 0, 0), "restart_unit_base");
        start = 1'b0;
        tick(ex(0, 8'd1, 1, 0, 0), "restart_unit_1");
        tick(ex(0, 8'd2, 1, 0, 0), "restart_unit_2");
        start = 1'b1; mode = 2'b01; dir = 1'b1; limit = 8'd10;
        tick(ex(0, 8'd10, 1, 0, 0), "restart_even_down_no_tc");
        start = 1'b0; mode = 2'b00; dir = 1'b0; limit = 8'd0;
        tick(ex(0, 8'd8, 1, 0, 0), "latched_cfg_8");
        tick(ex(0, 8'd6, 1, 0, 0), "latched_cfg_6");

        // Empty range: odd mode with limit 0 stays at base and pulses every enabled cycle.
        start = 1'b1; mode = 2'b00; dir = 1'b0; limit = 8'd0;
        tick(ex(0, 8'd1, 1, 0, 0), "empty_base");
        start = 1'b0;
        tick(ex(0, 8'd1, 1, 1, 0), "empty_tc_a");
        tick(ex(0, 8'd1, 1, 1, 0), "empty_tc_b");
        en = 1'b0;
        tick(ex(0, 8'd1, 1, 0, 0), "empty_disabled");

        // Programmable step 0 behaves as 1.
        start = 1'b1; en = 1'b1; mode = 2'b11; step = 8'd0; limit = 8'd2;
        tick(ex(0, 8'd0, 1, 0, 0), "step0_base");
        start = 1'b0;
        tick(ex(0, 8'd1, 1, 0, 0), "step0_1");
        tick(ex(0, 8'd2, 1, 0, 0), "step0_2");
        tick(ex(0, 8'd0, 1, 1, 0), "step0_wrap_tc");

        // Programmable down, step 3 from 10: reload to the high bound.
        start = 1'b1; mode = 2'b11; step = 8'd3; limit = 8'd10; dir = 1'b1;
        tick(ex(0, 8'd10, 1, 0, 0), "pdown_base");
        start = 1'b0;
        tick(ex(0, 8'd7, 1, 0, 0), "pdown_7");
        tick(ex(0, 8'd4, 1, 0, 0), "pdown_4");
        tick(ex(0, 8'd1, 1, 0, 0), "pdown_1");
        tick(ex(0, 8'd10, 1, 1, 0), "pdown_wrap_tc");

        // Saturating instance: even down from limit 7, then restart from DONE.
        start = 1'b1; mode = 2'b01; dir = 1'b1; limit = 8'd7;
        tick(ex(1, 8'd6, 1, 0, 0), "sat_base");
        start = 1'b0;
        tick(ex(1, 8'd4, 1, 0, 0), "sat_4");
        tick(ex(1, 8'd2, 1, 0, 0), "sat_2");
        tick(ex(1, 8'd0, 1, 0, 0), "sat_0");
        tick(ex(1, 8'd0, 0, 1, 1), "sat_done_tc");
        tick(ex(1, 8'd0, 0, 0, 1), "sat_done_hold");
        en = 1'b0;
        tick(ex(1, 8'd0, 0, 0, 1), "sat_done_hold_noen");
        start = 1'b1; en = 1'b1; mode = 2'b10; dir = 1'b0; limit = 8'd3;
        tick(ex(1, 8'd0, 1, 0, 0), "sat_restart_from_done");
        start = 1'b0;
        tick(ex(1, 8'd1, 1, 0, 0), "sat_unit_1");
        tick(ex(1, 8'd2, 1, 0, 0), "sat_unit_2");
        tick(ex(1, 8'd3, 1, 0, 0), "sat_unit_3");
        tick(ex(1, 8'd3, 0, 1, 1), "sat_unit_done_tc");

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/step_counter.md
STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the count width in bits.
REQ-002 The block SHALL have parameter SATURATE, default 0; 0 = wrap at terminal, 1 = stop at terminal.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: latches the configuration and loads the base value.
REQ-006 The block SHALL have port en, input, 1 bit: count enable while running.
REQ-007 The block SHALL have port dir, input, 1 bit: 0 = up, 1 = down; latched on start.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 odd, 01 even, 10 unit, 11 programmable; latched on start.
REQ-009 The block SHALL have port step, input, WIDTH bits: step size for mode 11; latched on start.
REQ-010 The block SHALL have port limit, input, WIDTH bits: upper bound of the sequence; latched on start.
REQ-011 The block SHALL have port out, output, WIDTH bits: current count.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-013 The block SHALL have port tc, output, 1 bit: one-cycle terminal-count pulse.
REQ-014 The block SHALL have port done, output, 1 bit: high in DONE (SATURATE=1 only).

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE with start=1, the next state SHALL be RUN, with out loaded with base on the same edge.
REQ-017 Base SHALL be the low bound when up and the high bound when down.
REQ-018 The low bound SHALL be 1 for odd mode and 0 for all other modes.
REQ-019 The high bound SHALL be: odd mode, limit with LSB forced to 1; even mode, limit with LSB forced to 0; other modes, limit.
REQ-020 The effective step SHALL be 2 for odd and even modes, 1 for unit mode, and step for programmable mode (step=0 treated as 1).
REQ-021 In RUN with en=1, out SHALL advance by the effective step per cycle, up or down per the latched dir; with en=0, out SHALL hold.
REQ-022 Terminal detection SHALL use WIDTH+1-bit arithmetic with no silent overflow: terminal when out+step exceeds the high bound (up) or out-step falls below the low bound (down).
REQ-023 At terminal with SATURATE=0, out SHALL reload base, tc SHALL pulse for that cycle, and the state SHALL remain RUN.
REQ-024 At terminal with SATURATE=1, out SHALL hold, tc SHALL pulse, and the state SHALL become DONE.
REQ-025 start in RUN or DONE SHALL restart: relatch the configuration, load base, enter RUN, with no tc pulse; start SHALL take priority over en.
REQ-026 DONE SHALL exit only on start or rst.
REQ-027 Latency SHALL be: out equals base 1 cycle after start is sampled; the first advance occurs on the next edge with en=1.
REQ-028 If limit is less than the low bound, out SHALL stay at base and tc SHALL pulse on every enabled cycle.

Reset
REQ-029 When rst=1 at an edge, the state SHALL become IDLE with out=0, busy=0, tc=0 and done=0, overriding start and en, including mid-count.
REQ-030 Latched configuration registers SHALL clear to mode=00, dir=0, step=0, limit=0.

Structure
REQ-031 Package counter_pkg SHALL hold the mode and state enums and the effective-step function.
REQ-032 Sub-module step_counter_next SHALL be combinational and compute the next value and the terminal flag from out, step, bounds and dir.

Verification
REQ-033 Odd up: WIDTH=8, limit=9, start, en=1 -> out 1,3,5,7,9,1; tc pulses on the reload to 1.
REQ-034 Even down with SATURATE=1: limit=7 -> out 6,4,2,0 then hold; tc pulses once; done=1, busy=0.
REQ-035 Programmable: step=50, limit=255 -> out 0,50,100,150,200,250,0; no 8-bit overflow wrap to 44.
REQ-036 en toggled 1,0,0,1 in unit mode -> out 0,1,1,1,2.
REQ-037 rst mid-count at out=5 -> the next cycle has out=0 and busy=0; start mid-count with a new mode -> the new base with no tc.
